ex_stage_mdu: RTL and testbench

Parametrised execute stage for the pipelined CPU. It selects operands through an N-source priority forwarding network and performs single-cycle ALU and branch-compare operations. It also runs an iterative multiply/divide unit that owns the HI/LO registers and stalls the upstream pipeline while busy. The result is registered into the EX/MEM pipeline outputs.

---
 rtl/ex_stage_mdu.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - execute stage with priority forwarding, single-cycle ALU and iterative mul/div
module ex_stage_mdu #(
    parameter int W = 32,
    parameter int NUM_FWD = 2,
    localparam int SW = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic [3:0]           op,
    input  logic                 sign,
    input  logic [4:0]           rs,
    input  logic [4:0]           rt,
    input  logic [W-1:0]         rs_data,
    input  logic [W-1:0]         rt_data,
    input  logic [W-1:0]         imm,
    input  logic                 alu_src2,
    input  logic [SW-1:0]        shamt,
    input  logic                 shamt_sel,
    input  logic [4:0]           wreg,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 branch,
    input  logic [5*NUM_FWD-1:0] fwd_rd,
    input  logic [W*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]   fwd_we,
    output logic                 stall,
    output logic                 branch_taken,
    output logic                 out_valid,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic [W-1:0]         out_result,
    output logic [W-1:0]         out_store_data,
    output logic [4:0]           out_wreg
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   cnt, sh_amt;
    logic [W-1:0]    a_fw, b_fw, op_b, alu_res, hi, lo;
    logic [W-1:0]    acc_hi, acc_lo, dsor, mag_a, mag_b;
    logic [W-1:0]    step_hi, step_lo, q_fix, r_fix;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [2*W-1:0]  prod_fix;
    logic            is_md, lt, start, md_div, neg_q, neg_r, dz;

    // Walk from lowest priority upward so the lowest matching index is applied last.
    always_comb begin
        a_fw = rs_data;
        b_fw = rt_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_rd[5*i +: 5] == rs && rs != 5'd0) a_fw = fwd_data[W*i +: W];
            if (fwd_we[i] && fwd_rd[5*i +: 5] == rt && rt != 5'd0) b_fw = fwd_data[W*i +: W];
        end
    end

    assign op_b   = alu_src2 ? imm : b_fw;
    assign sh_amt = shamt_sel ? shamt : a_fw[SW-1:0];
    assign is_md  = (op == 4'd12) || (op == 4'd13);

    always_comb begin
        lt = sign ? ($signed(a_fw) < $signed(op_b)) : (a_fw < op_b);
        case (op)
            4'd0:    alu_res = a_fw + op_b;
            4'd1:    alu_res = a_fw - op_b;
            4'd2:    alu_res = a_fw & op_b;
            4'd3:    alu_res = a_fw | op_b;
            4'd4:    alu_res = a_fw ^ op_b;
            4'd5:    alu_res = ~(a_fw | op_b);
            4'd6:    alu_res = {{(W-1){1'b0}}, lt};
            4'd7:    alu_res = op_b << sh_amt;
            4'd8:    alu_res = op_b >> sh_amt;
            4'd9:    alu_res = $signed(op_b) >>> sh_amt;
            4'd10:   alu_res = {{(W-1){1'b0}}, a_fw == b_fw};
            4'd11:   alu_res = {{(W-1){1'b0}}, a_fw != b_fw};
            4'd14:   alu_res = hi;
            4'd15:   alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        start   = 1'b0;
        case (state)
            S_IDLE: if (in_valid && is_md && !flush) begin
                start   = 1'b1;
                stall   = 1'b1;
                state_n = S_RUN;
            end
            S_RUN: begin
                stall = 1'b1;
                if (cnt == '0) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    assign branch_taken = in_valid & branch & alu_res[0] & ~stall & ~flush;

    // One iteration of shift-add multiply / restoring divide on magnitudes.
    always_comb begin
        mag_a     = (sign && a_fw[W-1]) ? -a_fw : a_fw;
        mag_b     = (sign && b_fw[W-1]) ? -b_fw : b_fw;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dsor} : {(W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, dsor};
        if (md_div) begin
            step_hi = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            step_lo = {acc_lo[W-2:0], ~div_diff[W]};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo[W-1:1]};
        end
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        q_fix    = dz ? '1 : (neg_q ? -step_lo : step_lo);
        r_fix    = neg_r ? -step_hi : step_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dsor   <= '0;
            md_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                md_div <= (op == 4'd13);
                dsor   <= (op == 4'd13) ? mag_b : mag_a;
                acc_hi <= '0;
                acc_lo <= (op == 4'd13) ? mag_a : mag_b;
                neg_q  <= sign & (a_fw[W-1] ^ b_fw[W-1]);
                neg_r  <= sign & a_fw[W-1];
                dz     <= (b_fw == '0);
                cnt    <= SW'(W - 1);
            end else if (state == S_RUN && !flush) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (cnt == '0) begin
                    if (md_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end else begin
                    cnt <= cnt - SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_wreg       <= '0;
        end else if (stall || flush || !in_valid) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_wreg       <= '0;
        end else begin
            out_valid      <= 1'b1;
            out_reg_write  <= reg_write & ~branch_taken & ~is_md;
            out_mem_read   <= mem_read & ~branch_taken;
            out_mem_write  <= mem_write & ~branch_taken;
            out_result     <= alu_res;
            out_store_data <= b_fw;
            out_wreg       <= wreg;
        end
    end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - self-checking bench for ex_stage_mdu against an arithmetic reference model
module tb_ex_stage_mdu;
    logic        clk = 1'b0;
    logic        reset, in_valid, flush, sign, alu_src2, shamt_sel;
    logic        reg_write, mem_read, mem_write, branch;
    logic [3:0]  op;
    logic [4:0]  rs, rt, shamt, wreg;
    logic [31:0] rs_data, rt_data, imm;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_we;
    logic        stall, branch_taken, out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_wreg;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

    ex_stage_mdu #(.W(32), .NUM_FWD(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush), .op(op), .sign(sign),
        .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src2(alu_src2),
        .shamt(shamt), .shamt_sel(shamt_sel), .wreg(wreg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .fwd_we(fwd_we), .stall(stall), .branch_taken(branch_taken),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_result(out_result), .out_store_data(out_store_data),
        .out_wreg(out_wreg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; flush = 0; op = 0; sign = 0; rs = 0; rt = 0; rs_data = 0; rt_data = 0;
        imm = 0; alu_src2 = 0; shamt = 0; shamt_sel = 0; wreg = 0; reg_write = 0;
        mem_read = 0; mem_write = 0; branch = 0; fwd_rd = 0; fwd_data = 0; fwd_we = 0;
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] r, input logic [31:0] rf);
        for (int i = 0; i < 2; i++)
            if (fwd_we[i] && fwd_rd[5*i +: 5] == r && r != 5'd0) return fwd_data[32*i +: 32];
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input int o, input bit sg, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] bfw, input int sa);
        logic [63:0] ext;
        case (o)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return sg ? 32'(longint'($signed(a)) < longint'($signed(b))) : 32'(a < b);
            7: return b << sa;
            8: return b >> sa;
            9: begin ext = {{32{b[31]}}, b} >> sa; return ext[31:0]; end
            10: return 32'(a == bfw);
            11: return 32'(a != bfw);
            14: return hi_m;
            15: return lo_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [3:0] mop, input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint q, r;
        if (mop == 4'd12) begin
            p = sg ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'd0, a} * {32'd0, b};
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (b == 32'd0) begin
            lo_m = 32'hFFFF_FFFF;
            hi_m = a;
        end else if (sg) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            lo_m = q[31:0];
            hi_m = r[31:0];
        end else begin
            lo_m = a / b;
            hi_m = a % b;
        end
    endtask

    task automatic read_hilo(input string tag);
        clear_in();
        in_valid = 1; reg_write = 1; op = 4'd14;
        #1 check({tag, "_mfhi_stall"}, stall, 0);
        tick();
        check({tag, "_hi"}, out_result, hi_m);
        op = 4'd15;
        tick();
        check({tag, "_lo"}, out_result, lo_m);
        clear_in();
    endtask

    task automatic start_md(input logic [3:0] mop, input bit sg, input logic [31:0] a, input logic [31:0] b);
        clear_in();
        in_valid = 1; op = mop; sign = sg; reg_write = 1; wreg = 5'd9;
        rs = 5'd1; rs_data = a; rt = 5'd2; rt_data = b;
        alu_src2 = 1; imm = $urandom;
    endtask

    task automatic run_md(input string tag, input logic [3:0] mop, input bit sg,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        start_md(mop, sg, a, b);
        #1;
        n = 0;
        for (int k = 0; k < 100 && stall; k++) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, n, 33);
        tick();
        check({tag, "_done_valid"}, out_valid, 1);
        check({tag, "_done_rw"}, out_reg_write, 0);
        md_ref(mop, sg, a, b);
        read_hilo(tag);
    endtask

    task automatic alu_vec(input string tag, input int o, input logic [31:0] exp_res);
        op = 4'(o);
        in_valid = 1;
        tick();
        check({tag, "_result"}, out_result, exp_res);
    endtask

    initial begin
        logic [31:0] a, bfw, b, res;
        logic        v, bt;
        int          ops[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15};
        int          o;

        clear_in();
        reset = 1;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_rw", out_reg_write, 0);
        check("rst_stall", stall, 0);
        check("rst_bt", branch_taken, 0);
        tick();
        reset = 0;
        tick();

        // forwarding priority and r0 exclusion
        rs = 5'd5; rs_data = 32'd10; rt = 5'd6; rt_data = 32'd1; reg_write = 1; wreg = 5'd3;
        fwd_rd = {5'd5, 5'd5}; fwd_data = {32'd200, 32'd100}; fwd_we = 2'b11;
        alu_vec("add_fwd0", 0, 32'd101);
        check("add_valid", out_valid, 1);
        check("add_rw", out_reg_write, 1);
        check("add_wreg", out_wreg, 3);
        fwd_we = 2'b10;
        alu_vec("add_fwd1", 0, 32'd201);
        rs = 5'd0; fwd_rd = {5'd0, 5'd0}; fwd_we = 2'b11;
        alu_vec("add_r0", 0, 32'd11);

        clear_in();
        rs = 5'd1; rs_data = 32'hFFFF_FFFF; rt = 5'd2; rt_data = 32'd1; sign = 1;
        alu_vec("slt_signed", 6, 32'd1);
        sign = 0;
        alu_vec("slt_unsigned", 6, 32'd0);
        rt_data = 32'h8000_0000; shamt = 5'd4; shamt_sel = 1;
        alu_vec("sra", 9, 32'hF800_0000);

        clear_in();
        rs = 5'd1; rs_data = 32'd5; rt = 5'd2; rt_data = 32'd5; branch = 1; reg_write = 1; in_valid = 1; op = 4'd10;
        #1 check("beq_taken", branch_taken, 1);
        tick();
        check("beq_valid", out_valid, 1);
        check("beq_rw", out_reg_write, 0);
        rt_data = 32'd6;
        #1 check("beq_not_taken", branch_taken, 0);
        tick();
        check("beq_nt_rw", out_reg_write, 1);
        clear_in();

        run_md("mult_dir", 4'd12, 1, 32'd7, 32'hFFFF_FFFD);
        check("mult_hi_const", hi_m, 64'hFFFF_FFFF);
        run_md("div_dir", 4'd13, 1, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", lo_m, 64'hFFFF_FFFD);
        run_md("div0", 4'd13, 0, 32'd9, 32'd0);
        run_md("div0_neg", 4'd13, 1, 32'hFFFF_FFF0, 32'd0);

        for (int it = 0; it < 10; it++) begin
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_md("md_rand", ($urandom_range(0, 1) != 0) ? 4'd12 : 4'd13, $urandom_range(0, 1) != 0, a, b);
        end

        // flush in the middle of RUN keeps HI/LO
        start_md(4'd12, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) tick();
        flush = 1;
        tick();
        clear_in();
        #1 check("flush_stall", stall, 0);
        check("flush_bubble", out_valid, 0);
        read_hilo("flush");

        // asynchronous reset mid-RUN
        start_md(4'd12, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (6) tick();
        reset = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_result", out_result, 0);
        in_valid = 0;
        #1 check("arst_stall", stall, 0);
        reset = 0;
        hi_m = 0;
        lo_m = 0;
        tick();
        read_hilo("arst");

        for (int it = 0; it < 150; it++) begin
            clear_in();
            o = ops[$urandom_range(0, 13)];
            in_valid = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 7) == 0);
            sign = $urandom_range(0, 1) != 0;
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            rs_data = $urandom; rt_data = $urandom; imm = $urandom;
            alu_src2 = $urandom_range(0, 1) != 0;
            shamt = 5'($urandom); shamt_sel = $urandom_range(0, 1) != 0;
            wreg = 5'($urandom); reg_write = $urandom_range(0, 1) != 0;
            mem_read = $urandom_range(0, 1) != 0; mem_write = $urandom_range(0, 1) != 0;
            branch = $urandom_range(0, 1) != 0;
            fwd_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data = {$urandom, $urandom}; fwd_we = 2'($urandom);
            op = 4'(o);
            a = fwd_ref(rs, rs_data);
            bfw = fwd_ref(rt, rt_data);
            b = alu_src2 ? imm : bfw;
            res = alu_ref(o, sign, a, b, bfw, shamt_sel ? int'(shamt) : int'(a[4:0]));
            v = in_valid & ~flush;
            bt = v & branch & res[0];
            #1;
            check("rnd_bt", branch_taken, bt);
            check("rnd_stall", stall, 0);
            tick();
            check("rnd_valid", out_valid, v);
            check("rnd_rw", out_reg_write, v & reg_write & ~bt);
            check("rnd_mr", out_mem_read, v & mem_read & ~bt);
            check("rnd_mw", out_mem_write, v & mem_write & ~bt);
            if (v) begin
                check("rnd_result", out_result, res);
                check("rnd_store", out_store_data, bfw);
                check("rnd_wreg", out_wreg, wreg);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
